// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared constants and types for the Sysbus memory-side responder.
//   BURST_LEN     - beats per line transaction (8 x 64-bit = one 64-byte line)
//   BEAT_W        - width of the in-line beat index
//   LINE_OFFSET   - byte-address bit where the line index starts
//   TAG_WRITE_BIT - write-flag position for the default 13-bit tag
//   ST_*          - FSM encodings, also exported on the debug state port
package sysbus_pkg;

  localparam int BURST_LEN     = 8;
  localparam int BEAT_W        = 3;
  localparam int LINE_OFFSET   = 6;
  localparam int TAG_WRITE_BIT = 12;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_DATA  = 2'd1;
  localparam logic [1:0] ST_RD_WAIT  = 2'd2;
  localparam logic [1:0] ST_RD_BURST = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_WR_DATA  = ST_WR_DATA,
    S_RD_WAIT  = ST_RD_WAIT,
    S_RD_BURST = ST_RD_BURST
  } sysbus_resp_state_t;

endpackage

// File: rtl/sysbus_line_ram.sv
// sysbus_line_ram: single-port synchronous RAM holding the responder's lines.
// One access per cycle; the read is registered (data appears after the edge
// that sampled the address). Contents are not reset.
//   clk      - clock
//   we_i     - write enable for addr_i
//   addr_i   - word address {line, beat}
//   wdata_i  - write data
//   rdata_o  - registered read data of the word addressed on the previous edge
module sysbus_line_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sysbus_responder.sv
// sysbus_responder: memory-side Sysbus responder backed by a local line store.
// Handshake rule (both channels): a beat transfers on a rising clk edge where
// the source's valid (reqcyc / respcyc) and the sink's ready (reqack / respack)
// are both high; the source holds its beat unchanged until that edge.
//   clk       - clock
//   reset     - asynchronous active-low reset
//   req       - address beat (line index at bit 6) or write data beat
//   reqtag    - request tag, MSB = write flag; captured on the address beat
//   reqcyc    - request beat valid
//   reqack    - responder ready for a request beat
//   resp      - read data beat (0 when respcyc is low)
//   resptag   - tag of the read being returned (0 when respcyc is low)
//   respcyc   - response beat valid
//   respack   - initiator ready for a response beat
//   dbg_state - current FSM state encoding
module sysbus_responder
  import sysbus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int MEM_LINES  = 256,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] req,
  input  logic [TAG_WIDTH-1:0]  reqtag,
  input  logic                  reqcyc,
  output logic                  reqack,
  output logic [DATA_WIDTH-1:0] resp,
  output logic [TAG_WIDTH-1:0]  resptag,
  output logic                  respcyc,
  input  logic                  respack,
  output logic [1:0]            dbg_state
);

  localparam int LINE_W = $clog2(MEM_LINES);
  localparam int ADDR_W = LINE_W + BEAT_W;
  localparam int LAT_W  = $clog2(LATENCY);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  sysbus_resp_state_t   state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  // Low through reset and for the first edge after release, so reqack
  // cannot accept a beat that was already waiting when reset released.
  logic                 alive_q;

  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign reqack  = alive_q && (state_q == S_IDLE || state_q == S_WR_DATA);
  assign respcyc = (state_q == S_RD_BURST);
  assign resp    = respcyc ? ram_rdata : '0;
  assign resptag = respcyc ? tag_q : '0;
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    line_d   = line_q;
    tag_d    = tag_q;
    ram_we   = 1'b0;
    ram_addr = {line_q, beat_q};
    case (state_q)
      S_IDLE: begin
        if (reqcyc && reqack) begin
          line_d = req[LINE_OFFSET +: LINE_W];
          tag_d  = reqtag;
          beat_d = '0;
          if (reqtag[TAG_WIDTH-1]) begin
            state_d = S_WR_DATA;
          end else begin
            state_d = S_RD_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end
      S_WR_DATA: begin
        if (reqcyc && reqack) begin
          ram_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RD_WAIT: begin
        // Word 0 is read on the edge that enters RD_BURST, so it is
        // visible in the first burst cycle.
        ram_addr = {line_q, {BEAT_W{1'b0}}};
        if (lat_q == '0) begin
          state_d = S_RD_BURST;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RD_BURST: begin
        // Prefetch: on a handshake fetch word k+1, otherwise re-read word k
        // so the registered RAM output holds steady under backpressure.
        ram_addr = {line_q, beat_q + BEAT_W'(respack)};
        if (respack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      line_q  <= '0;
      tag_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      alive_q <= 1'b1;
    end
  end

  sysbus_line_ram #(
    .DEPTH (MEM_LINES * BURST_LEN),
    .AW    (ADDR_W),
    .DW    (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (req),
    .rdata_o (ram_rdata)
  );

endmodule
